// File: rtl/fp_wb_arbiter.sv
// FP register-file write-back arbiter.
// Three result producers (0 = FMA/add, 1 = div/sqrt, 2 = FP load) hand results
// over valid/ready. A round-robin arbiter admits at most one result per cycle
// into an in-order FIFO whose head drives the single register-file write port.
// The write port holds still while the MEM/WB freeze is asserted. A mask of
// destinations still queued is exported for issue-side hazard checks.
module fp_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       SRC_VALID,
    output logic [2:0]       SRC_READY,
    input  logic [4:0]       SRC0_ADDR,
    input  logic [4:0]       SRC1_ADDR,
    input  logic [4:0]       SRC2_ADDR,
    input  logic [63:0]      SRC0_DATA,
    input  logic [63:0]      SRC1_DATA,
    input  logic [63:0]      SRC2_DATA,
    input  logic             SRC0_SP_DP,
    input  logic             SRC1_SP_DP,
    input  logic             SRC2_SP_DP,
    input  logic             FP__MEM_WB_Freeze,
    output logic             FP__Reg_Write_En__EX_MEM,
    output logic [4:0]       FP__RD_Write_Addr,
    output logic [63:0]      FP__RD_Write_Data,
    output logic             FP__SP_DP__EX_MEM,
    output logic [31:0]      WB_PENDING,
    output logic [PTR_W:0]   FIFO_COUNT
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [1:0]       last_grant_q;

    logic [4:0]       addr_mem [DEPTH];
    logic [63:0]      data_mem [DEPTH];
    logic             dp_mem   [DEPTH];

    logic             head_en, pop, space, push;
    logic [2:0]       grant;
    logic [1:0]       grant_idx;
    logic [4:0]       push_addr;
    logic [63:0]      push_data;
    logic             push_dp;
    logic [PTR_W-1:0] age;
    logic [31:0]      pending;

    // First valid source in the priority order a, b, c wins.
    function automatic logic [2:0] pick3(input logic [2:0] v, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] c);
        logic [2:0] r;
        r = '0;
        if (v[a])      r[a] = 1'b1;
        else if (v[b]) r[b] = 1'b1;
        else if (v[c]) r[c] = 1'b1;
        return r;
    endfunction

    // Write-port enable, pop and free-space qualification.
    always_comb begin
        head_en = (count_q != '0) && !RST;
        pop     = head_en && !FP__MEM_WB_Freeze;
        space   = ((count_q < DEPTH_C) || pop) && !RST;
    end

    // Round-robin grant, scanning from the source after the last winner.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant = '0;
        if (space) begin
            case (last_grant_q)
                2'd0:    grant = pick3(SRC_VALID, 2'd1, 2'd2, 2'd0);
                2'd1:    grant = pick3(SRC_VALID, 2'd2, 2'd0, 2'd1);
                default: grant = pick3(SRC_VALID, 2'd0, 2'd1, 2'd2);
            endcase
        end
    end

    // Encode the winner and select its payload for the FIFO write.
    always_comb begin
        push      = |grant;
        grant_idx = 2'd0;
        push_addr = SRC0_ADDR;
        push_data = SRC0_DATA;
        push_dp   = SRC0_SP_DP;
        if (grant[1]) begin
            grant_idx = 2'd1;
            push_addr = SRC1_ADDR;
            push_data = SRC1_DATA;
            push_dp   = SRC1_SP_DP;
        end else if (grant[2]) begin
            grant_idx = 2'd2;
            push_addr = SRC2_ADDR;
            push_data = SRC2_DATA;
            push_dp   = SRC2_SP_DP;
        end
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    // Pointer, occupancy and arbitration state; RST flushes the queue.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (RST) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            last_grant_q <= 2'd2;
        end else begin
            count_q <= count_d;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                last_grant_q <= grant_idx;
            end
        end
    end

    // Result storage; an entry is written when its source is accepted.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array has no reset; entries are only observed through count, so their contents never matter until written.
        if (push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
            dp_mem[wr_ptr_q]   <= push_dp;
        end
    end

    // Destination mask of the entries currently queued (head-relative age < count).
    always_comb begin
        pending = '0;
        age     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, age} < count_q) && !RST) pending = pending | (32'd1 << addr_mem[i]);
        end
    end

    assign SRC_READY                = grant;
    assign FP__Reg_Write_En__EX_MEM = head_en;
    assign FP__RD_Write_Addr        = addr_mem[rd_ptr_q];
    assign FP__RD_Write_Data        = data_mem[rd_ptr_q];
    assign FP__SP_DP__EX_MEM        = dp_mem[rd_ptr_q];
    assign WB_PENDING               = pending;
    assign FIFO_COUNT               = RST ? '0 : count_q;

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
Writer side of the FP register file write port. Collects FP results from three producers (0 = FMA/add pipe, 1 = div/sqrt unit, 2 = FP load path) over valid/ready handshakes, arbitrates round-robin and buffers accepted results in an in-order FIFO. It drives the register file's single write port one entry per cycle and honours the MEM/WB freeze. It also exports a pending-destination mask that issue logic uses for hazard checks.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, at least 2)
PTR_W, 2, log2(DEPTH)

Ports:
CLK  in  1  clock
RST  in  1  reset
SRC_VALID  in  3  per-source result valid
SRC_READY  out  3  per-source accept; one-hot or zero
SRC0_ADDR / SRC1_ADDR / SRC2_ADDR  in  5 each  destination f-register
SRC0_DATA / SRC1_DATA / SRC2_DATA  in  64 each  result data
SRC0_SP_DP / SRC1_SP_DP / SRC2_SP_DP  in  1 each  1 = double, 0 = single
FP__MEM_WB_Freeze  in  1  stall; the write port must not advance
FP__Reg_Write_En__EX_MEM  out  1  write enable to the register file
FP__RD_Write_Addr  out  5  write address
FP__RD_Write_Data  out  64  write data, passed unmodified; NaN-boxing is done by the register file
FP__SP_DP__EX_MEM  out  1  precision of the write
WB_PENDING  out  32  bit i set while any valid FIFO entry targets f[i]
FIFO_COUNT  out  PTR_W+1  occupancy

Behaviour:
- Reset: RST is synchronous and active-high, clocked on CLK. While RST is high: count=0, rd/wr pointers=0, last_grant=2, SRC_READY=0, write enable=0, WB_PENDING=0. Data/addr outputs are don't-care while enable=0 (drive head entry).
- Reset mid-operation flushes all queued entries; they are never written. A source holding VALID simply re-presents after reset.
- Write port:
  - FP__Reg_Write_En__EX_MEM = (count != 0).
  - Addr, data and SP_DP come from the FIFO head entry, which is a registered storage output.
  - pop = en & ~freeze. Head advances on the edge where pop=1.
- Freeze: head and enable are held stable while freeze=1. Pushes continue while space remains.
- Space: space = (count < DEPTH) | pop. Pushing into a full FIFO in the same cycle as a pop is legal.
- Arbitration:
  - Only when space=1 and RST=0.
  - Among asserted SRC_VALID, scan starting at (last_grant+1) mod 3. The first valid source gets SRC_READY=1.
  - last_grant updates to the winner on transfer.
  - At most one push per cycle. SRC_READY is combinational from valid, count and freeze.
- Handshake: transfer on VALID & READY at the edge. A source must hold VALID and payload stable until accepted. The block never drops an accepted result.
- Latency: a result accepted at edge N into an empty FIFO presents en=1 during cycle N+1. It commits at edge N+2 absent freeze. No combinational bypass from source to write port.
- Count update: count' = count + push − pop. Simultaneous push and pop leaves count unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Ordering: entries commit in acceptance order. Two writes to the same rd commit in that order (last wins).
- WB_PENDING: combinational OR over valid entries of the one-hot decode of addr. It is the mask of valid entries only and does not include a source still waiting for READY. f0 is an ordinary register.
- Invariants (bench assertions): count ≤ DEPTH; SRC_READY is one-hot-or-zero; a pop never occurs with count=0.

Test Plan:
- Single write: src0 sends addr=5, data=0x40FE240000000000, dp=1 at cycle 0 → en=1, addr=5, data unchanged in cycle 1; count returns to 0 after edge 2; WB_PENDING[5] is high only in cycle 1.
- Round-robin: all three VALID continuously, 4 results each → grant order 0,1,2,0,1,2…; write port commits in the same order, no source starved.
- Freeze/full: freeze=1 for 8 cycles with src1 streaming addrs 1,2,3,4,5 → 4 accepted, count=4, READY low for the 5th. Head addr=1 stays stable. Releasing freeze → in the first cycle the 5th entry is pushed while addr=1 pops.
- SP pass-through: src2 sends addr=31, data=0x00000000C0E64DC0, sp_dp=0 → write port carries identical data with SP_DP=0.
- Same-rd ordering: src0 sends addr=7 data A, then src1 sends addr=7 data B → A written before B; WB_PENDING[7] stays high until B commits.
- Reset mid-operation: 3 entries queued, assert RST for 1 cycle → en=0, count=0, WB_PENDING=0; the next accepted grant goes to source 0.
